dict_writer: RTL and testbench
==============================

DICT_WRITER -- requirements
Module: dict_writer

Interface
REQ-001 SHALL have parameter DICT_START, default 1, BRAM address of first dictionary entry.
REQ-002 SHALL have parameter DICT_SIZE, default 3, max dictionary entries accepted.
REQ-003 SHALL have port clk, input, 1, system clock (100 MHz), all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse opening a load session.
REQ-006 SHALL have ports byte_valid (input, 1), byte_data (input, 8) and byte_last (input, 1): source byte stream, where byte_last marks the final byte.
REQ-007 SHALL have port byte_ready, input-side handshake output, 1; a byte is accepted on a cycle where byte_valid and byte_ready are both 1.
REQ-008 SHALL have BRAM write ports ena (1), wea (1), addra (8) and dina (128), all outputs.
REQ-009 SHALL have status outputs busy (1), done (1), err (1) and count (8, words written).

Function
REQ-010 SHALL implement states IDLE, COLLECT, WRITE, DONE, ERROR.
REQ-011 SHALL go IDLE->COLLECT on start; start SHALL be ignored in COLLECT/WRITE; start in DONE/ERROR SHALL clear count/err/done and enter COLLECT.
REQ-012 SHALL drive byte_ready=1 only in COLLECT.
REQ-013 SHALL pack bytes MSB-first: first accepted byte of a word goes to dina[127:120], 16th to dina[7:0].
REQ-014 SHALL enter WRITE the cycle after the 16th byte of a word, or after a byte with byte_last=1.
REQ-015 SHALL zero-pad a partial word completed by byte_last.
REQ-016 SHALL assert wea=1, ena=1 for exactly one cycle in WRITE, with addra and dina stable that cycle; wea=0 in every other state.
REQ-017 SHALL write word 0 (target hash) to addra=0 and word k>=1 to addra=DICT_START+k-1.
REQ-018 SHALL increment count by 1 per write pulse.
REQ-019 SHALL return WRITE->COLLECT after a full word without byte_last, and WRITE->DONE after a word closed by byte_last.
REQ-020 SHALL, when a word would be word index DICT_SIZE+1, enter ERROR with err=1 instead of WRITE, with no write pulse.
REQ-021 SHALL hold done=1 in DONE and busy=1 in COLLECT/WRITE; both 0 otherwise.
REQ-022 SHALL treat byte_last on a byte that is also the 16th byte as a single word write followed by DONE, with no extra empty word.
REQ-023 SHALL keep count saturated-free: with DICT_SIZE<=254, count never exceeds DICT_SIZE+1.

Reset
REQ-024 SHALL, on reset low, asynchronously enter IDLE with byte_ready=0, wea=0, ena=0, addra=0, dina=0, busy=0, done=0, err=0, count=0.
REQ-025 SHALL, on reset mid-session, discard any partially packed word and issue no write pulse.
REQ-026 SHALL release reset synchronously to clk (first state change on the second rising edge after deassertion).

Configuration
REQ-027 SHALL, with macro DICT_WRITER_CHECKSUM_EN defined, add input csum_ref (8) and output csum (8) holding the XOR of all accepted bytes in the session, cleared on start.
REQ-028 SHALL, with DICT_WRITER_CHECKSUM_EN defined, on WRITE->DONE compare csum to csum_ref and enter ERROR with err=1 on mismatch (the final write still occurs).
REQ-029 SHALL, without DICT_WRITER_CHECKSUM_EN, have no csum/csum_ref ports and no checksum check.

Verification
REQ-030 Reset then start, 16 bytes 0x00..0x0F with last on 0x0F -> one wea pulse, addra=0, dina=0x000102..0F, done=1, count=1.
REQ-031 Start, 48 bytes (3 words), last on byte 48 -> writes to addra 0,1,2 in order, count=3, done=1.
REQ-032 Start, 5 bytes 0xAA with last on 5th -> dina=0xAAAAAAAAAA followed by 11 zero bytes at addra=0, done=1.
REQ-033 Start, 80 bytes (5 words) with DICT_SIZE=3 -> 4 writes (addra 0..3), then err=1, no 5th pulse, byte_ready=0.
REQ-034 Start, 20 bytes, reset low at byte 20 -> all outputs zero immediately, no write for the partial word; start after release behaves as a fresh session.
REQ-035 With DICT_WRITER_CHECKSUM_EN, 16 bytes 0x01 with csum_ref=0x00 -> csum=0x00, done=1; same with csum_ref=0x01 -> err=1.

Source files
------------

// File: rtl/dict_writer.sv
// dict_writer: packs a byte stream MSB-first into 128-bit BRAM words (word 0 = target hash at addr 0).
// Define DICT_WRITER_CHECKSUM_EN to add a session XOR checksum compared against csum_ref at the end.
module dict_writer #(
  parameter int DICT_START = 1,
  parameter int DICT_SIZE  = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic         ena,
  output logic         wea,
  output logic [7:0]   addra,
  output logic [127:0] dina,
  output logic         busy,
  output logic         done,
  output logic         err,
`ifdef DICT_WRITER_CHECKSUM_EN
  input  logic [7:0]   csum_ref,
  output logic [7:0]   csum,
`endif
  output logic [7:0]   count
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;
  localparam logic [7:0] LIMIT = 8'(DICT_SIZE + 1);
  state_t state_q, state_d;
  logic         rdy_q;
  logic [127:0] word_q, word_d;
  logic [3:0]   bcnt_q, bcnt_d;
  logic         last_q, last_d;
  logic [7:0]   count_q, count_d;
  logic         err_q, err_d;
  logic         restart, accept, csum_bad;
  assign restart = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign accept  = byte_valid && state_q == COLLECT;
  // Holds the FSM for one edge after reset release so it moves first on the second edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (rdy_q) begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
`ifdef DICT_WRITER_CHECKSUM_EN
  logic [7:0] csum_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) csum_q <= '0;
    else if (rdy_q) csum_q <= restart ? 8'h00 : accept ? csum_q ^ byte_data : csum_q;
  assign csum     = csum_q;
  assign csum_bad = csum_q != csum_ref;
`else
  assign csum_bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = COLLECT;
        word_d  = '0;
        bcnt_d  = '0;
        last_d  = 1'b0;
        count_d = '0;
        err_d   = 1'b0;
      end
      COLLECT: if (byte_valid) begin
        word_d[8*(15-int'(bcnt_q)) +: 8] = byte_data;
        bcnt_d = bcnt_q + 4'd1;
        last_d = byte_last;
        if (bcnt_q == 4'd15 || byte_last) begin
          state_d = count_q == LIMIT ? ERROR : WRITE;
          err_d   = count_q == LIMIT;
        end
      end
      WRITE: begin
        count_d = count_q + 8'd1;
        word_d  = '0;
        bcnt_d  = '0;
        state_d = !last_q ? COLLECT : csum_bad ? ERROR : DONE;
        err_d   = last_q && csum_bad;
      end
      default: state_d = IDLE;
    endcase
  end
  assign byte_ready = state_q == COLLECT;
  assign wea        = state_q == WRITE;
  assign ena        = state_q == WRITE;
  assign busy       = state_q == COLLECT || state_q == WRITE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign count      = count_q;
  assign dina       = word_q;
  assign addra      = count_q == 8'd0 ? 8'd0 : 8'(DICT_START) + count_q - 8'd1;
endmodule

// File: tb/tb_dict_writer.sv
// tb_dict_writer: randomized sessions checked against a queue-based reference of expected BRAM writes.
module tb_dict_writer;
  localparam int DS = 3;
  localparam int DST = 16;
  logic clk = 0, reset = 0, start = 0, byte_valid = 0, byte_last = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, ena, wea, busy, done, err;
  logic [7:0] addra, count;
  logic [127:0] dina;
`ifdef DICT_WRITER_CHECKSUM_EN
  logic [7:0] csum_ref = 0, csum;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [7:0] d_q[$];
  logic [7:0] got_a[$];
  logic [127:0] got_d[$];
  dict_writer #(.DICT_START(DST), .DICT_SIZE(DS)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .busy(busy), .done(done), .err(err),
`ifdef DICT_WRITER_CHECKSUM_EN
    .csum_ref(csum_ref), .csum(csum),
`endif
    .count(count));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (reset && (wea || ena)) begin
    check("ena_eq_wea", ena, wea);
    got_a.push_back(addra);
    got_d.push_back(dina);
  end
  task automatic send(input int cnt, input int n);
    for (int i = 0; i < cnt; i++) begin
      int w;
      while ($urandom_range(0, 3) == 0) begin
        byte_valid = 0;
        @(negedge clk);
      end
      byte_valid = 1;
      byte_data = d_q[i];
      byte_last = (i == n - 1);
      start = ($urandom_range(0, 9) == 0);
      w = 0;
      while (!byte_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!byte_ready) begin
        check("ready_timeout", byte_ready, 1'b1);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 0;
    byte_last = 0;
    start = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic run_session(input int n, input int mode, input bit bad_ref);
    int nw, nexp, acc;
    bit ovf, exp_err;
    logic [7:0] x;
    logic [127:0] w;
    d_q.delete();
    for (int i = 0; i < n; i++)
      d_q.push_back(mode == 0 ? 8'($urandom) : mode == 1 ? 8'(i) : 8'hAA);
    nw = (n + 15) / 16;
    ovf = nw > DS + 1;
    acc = ovf && n > 16 * (DS + 2) ? 16 * (DS + 2) : n;
    nexp = ovf ? DS + 1 : nw;
    x = 0;
    for (int i = 0; i < acc; i++) x ^= d_q[i];
    exp_err = ovf;
`ifdef DICT_WRITER_CHECKSUM_EN
    csum_ref = bad_ref ? x ^ 8'(1 + $urandom_range(0, 254)) : x;
    if (!ovf && bad_ref) exp_err = 1;
`endif
    got_a.delete();
    got_d.delete();
    pulse_start();
    send(acc, n);
    repeat (4) @(negedge clk);
    check("nwrites", got_a.size(), nexp);
    for (int k = 0; k < nexp && k < got_a.size(); k++) begin
      w = 0;
      for (int j = 0; j < 16; j++) w = {w[119:0], (16 * k + j < n) ? d_q[16 * k + j] : 8'h00};
      check("addra", got_a[k], k == 0 ? 0 : DST + k - 1);
      check("dina", got_d[k], w);
    end
    check("count", count, nexp);
    check("err", err, exp_err);
    check("done", done, !exp_err);
    check("busy", busy, 0);
    check("ready_end", byte_ready, 0);
`ifdef DICT_WRITER_CHECKSUM_EN
    check("csum", csum, x);
`endif
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_dina", dina, 0);
    check("rst_outs", {byte_ready, wea, ena, addra, busy, done, err, count}, 0);
    reset = 1;
    repeat (2) @(negedge clk);
    run_session(16, 1, 0);
    run_session(5, 2, 0);
    run_session(48, 0, 0);
    run_session(80, 0, 0);
    run_session(32, 0, 1);
    run_session(16 * (DS + 2), 0, 0);
    run_session(16 * (DS + 1), 0, 0);
    // Abort mid-session: word 0 is written, the partial second word must never be.
    got_a.delete();
    got_d.delete();
    d_q.delete();
    for (int i = 0; i < 20; i++) d_q.push_back(8'($urandom));
    pulse_start();
    send(19, 99);
    byte_valid = 1;
    byte_data = d_q[19];
    reset = 0;
    #1;
    check("abort_dina", dina, 0);
    check("abort_outs", {byte_ready, wea, ena, addra, busy, done, err, count}, 0);
    byte_valid = 0;
    repeat (3) @(negedge clk);
    check("abort_writes", got_a.size(), 1);
    reset = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_at_release", busy, 0);
    run_session(16, 1, 0);
    for (int s = 0; s < 25; s++)
      run_session($urandom_range(1, 90), 0, $urandom_range(0, 3) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
